// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared state encoding and read-mode constants for the dual-port RAM
package dpram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

endpackage

// File: rtl/dpram_clear_seq.sv
// rtl/dpram_clear_seq.sv - post-reset clear sweep counter and CLEAR/READY state machine
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   busy        high while the sweep is running (state CLEAR)
//   clear_we    write strobe for the sweep
//   clear_addr  location the sweep writes this cycle
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state;
    state_t                  state_nx;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy     = 1'b0;
        clear_we = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy     = 1'b1;
                clear_we = 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_nx = ST_READY;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign clear_addr = cnt;

endmodule

// File: rtl/dpram_sync_init.sv
// rtl/dpram_sync_init.sv - true dual-port RAM with registered reads, bypass modes and self-clear
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   din_x, addr_x            write data and shared read/write address, port A / B
//   we_x, re_x               write / read enable, port A / B
//   dout_x, valid_x          registered read data and its one-cycle strobe
//   busy                     reset or clear sweep in progress, requests ignored
//   collision                both ports wrote the same address last cycle
module dpram_sync_init
    import dpram_pkg::*;
#(
    parameter int                WIDTH      = 16,
    parameter int                ADDR_WIDTH = 7,
    parameter int                DEPTH      = 128,
    parameter int                READ_MODE  = READ_FIRST,
    parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din_a,
    input  logic [WIDTH-1:0]      din_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic                  re_a,
    input  logic                  re_b,
    output logic [WIDTH-1:0]      dout_a,
    output logic [WIDTH-1:0]      dout_b,
    output logic                  valid_a,
    output logic                  valid_b,
    output logic                  busy,
    output logic                  collision
);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic                  accept;
    logic                  in_a;
    logic                  in_b;
    logic                  wr_a;
    logic                  wr_b;
    logic                  same_addr;
    logic [WIDTH-1:0]      rd_a;
    logic [WIDTH-1:0]      rd_b;

    dpram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .busy       (busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    // A cycle with rst high is also ignored, even if the FSM still shows READY.
    assign accept    = !busy && !rst;
    assign in_a      = 32'(addr_a) < DEPTH;
    assign in_b      = 32'(addr_b) < DEPTH;
    assign same_addr = (addr_a == addr_b);
    assign wr_a      = accept && we_a && in_a;
    // Port B loses a same-address write collision, so its write is simply suppressed.
    assign wr_b      = accept && we_b && in_b && !(wr_a && same_addr);

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= INIT_VALUE;
        end else begin
            if (wr_a) mem[addr_a] <= din_a;
            if (wr_b) mem[addr_b] <= din_b;
        end
    end

    // Write-first bypass: port A's data takes priority, matching what gets stored.
    always_comb begin
        rd_a = '0;
        if (in_a) begin
            rd_a = mem[addr_a];
            if (READ_MODE == WRITE_FIRST) begin
                if (wr_b && same_addr) rd_a = din_b;
                if (wr_a)              rd_a = din_a;
            end
        end
    end

    always_comb begin
        rd_b = '0;
        if (in_b) begin
            rd_b = mem[addr_b];
            if (READ_MODE == WRITE_FIRST) begin
                if (wr_b)              rd_b = din_b;
                if (wr_a && same_addr) rd_b = din_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_a    <= '0;
            dout_b    <= '0;
            valid_a   <= 1'b0;
            valid_b   <= 1'b0;
            collision <= 1'b0;
        end else begin
            valid_a   <= accept && re_a;
            valid_b   <= accept && re_b;
            collision <= wr_a && accept && we_b && in_b && same_addr;
            if (accept && re_a) dout_a <= rd_a;
            if (accept && re_b) dout_b <= rd_b;
        end
    end

endmodule

// File: tb/tb_dpram_sync_init.sv
// tb/tb_dpram_sync_init.sv - randomized self-checking bench for dpram_sync_init against a reference model
module tb_dpram_sync_init;

    localparam int NI = 3;
    localparam int DEP [NI] = '{128, 128, 100};
    localparam int RM  [NI] = '{0, 1, 0};
    localparam logic [15:0] INI [NI] = '{16'hA5A5, 16'h1111, 16'h0F0F};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din_a = '0, din_b = '0;
    logic [6:0]  addr_a = '0, addr_b = '0;
    logic        we_a = 1'b0, we_b = 1'b0, re_a = 1'b0, re_b = 1'b0;

    logic [15:0] o_dout_a [NI];
    logic [15:0] o_dout_b [NI];
    logic        o_valid_a [NI];
    logic        o_valid_b [NI];
    logic        o_busy [NI];
    logic        o_col [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dpram_sync_init #(
            .WIDTH      (16),
            .ADDR_WIDTH (7),
            .DEPTH      (DEP[g]),
            .READ_MODE  (RM[g]),
            .INIT_VALUE (INI[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .din_a     (din_a),
            .din_b     (din_b),
            .addr_a    (addr_a),
            .addr_b    (addr_b),
            .we_a      (we_a),
            .we_b      (we_b),
            .re_a      (re_a),
            .re_b      (re_b),
            .dout_a    (o_dout_a[g]),
            .dout_b    (o_dout_b[g]),
            .valid_a   (o_valid_a[g]),
            .valid_b   (o_valid_b[g]),
            .busy      (o_busy[g]),
            .collision (o_col[g])
        );
    end

    // reference model
    logic [15:0] m_mem [NI][128];
    int          m_left [NI];
    logic [15:0] e_da [NI], e_db [NI];
    logic        e_va [NI], e_vb [NI], e_col [NI];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] model_read(input int i, input int ad);
        int aa, ab;
        aa = int'(addr_a);
        ab = int'(addr_b);
        if (ad >= DEP[i]) return 16'h0;
        if (RM[i] == 1) begin
            if (we_a && aa == ad) return din_a;
            if (we_b && ab == ad) return din_b;
        end
        return m_mem[i][ad];
    endfunction

    task automatic step();
        bit acc;
        int aa, ab;
        aa = int'(addr_a);
        ab = int'(addr_b);
        for (int i = 0; i < NI; i++) begin
            acc = !rst && (m_left[i] == 0);
            if (rst) begin
                e_da[i] = '0; e_db[i] = '0;
                e_va[i] = 1'b0; e_vb[i] = 1'b0; e_col[i] = 1'b0;
                for (int k = 0; k < 128; k++) m_mem[i][k] = INI[i];
                m_left[i] = DEP[i];
            end else begin
                if (m_left[i] > 0) m_left[i]--;
                e_va[i]  = acc && re_a;
                e_vb[i]  = acc && re_b;
                if (e_va[i]) e_da[i] = model_read(i, aa);
                if (e_vb[i]) e_db[i] = model_read(i, ab);
                e_col[i] = acc && we_a && we_b && aa == ab && aa < DEP[i];
                if (acc) begin
                    if (we_b && ab < DEP[i]) m_mem[i][ab] = din_b;
                    if (we_a && aa < DEP[i]) m_mem[i][aa] = din_a;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("u%0d.busy", i),      32'(o_busy[i]),    32'(m_left[i] > 0));
            check_val($sformatf("u%0d.valid_a", i),   32'(o_valid_a[i]), 32'(e_va[i]));
            check_val($sformatf("u%0d.valid_b", i),   32'(o_valid_b[i]), 32'(e_vb[i]));
            check_val($sformatf("u%0d.dout_a", i),    32'(o_dout_a[i]),  32'(e_da[i]));
            check_val($sformatf("u%0d.dout_b", i),    32'(o_dout_b[i]),  32'(e_db[i]));
            check_val($sformatf("u%0d.collision", i), 32'(o_col[i]),     32'(e_col[i]));
        end
    endtask

    task automatic idle();
        we_a = 1'b0; we_b = 1'b0; re_a = 1'b0; re_b = 1'b0;
    endtask

    task automatic rand_inputs(input bit narrow);
        we_a = 1'($urandom); we_b = 1'($urandom);
        re_a = 1'($urandom); re_b = 1'($urandom);
        din_a = 16'($urandom); din_b = 16'($urandom);
        addr_a = narrow ? 7'($urandom_range(0, 3)) : 7'($urandom);
        addr_b = narrow ? 7'($urandom_range(0, 3)) : 7'($urandom);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) m_left[i] = 0;
        rst = 1'b1; idle();
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 128; c++) step();
        check_val("busy_done", 32'(o_busy[0]), 32'd0);

        // clear contents
        re_a = 1'b1; addr_a = 7'd0; re_b = 1'b1; addr_b = 7'd64; step();
        check_val("clr_rd0", 32'(o_dout_a[0]), 32'hA5A5);
        check_val("clr_rd64", 32'(o_dout_b[0]), 32'hA5A5);
        re_b = 1'b0; addr_a = 7'd127; step();
        check_val("clr_rd127", 32'(o_dout_a[0]), 32'hA5A5);
        idle(); step();

        // basic write then cross-port read
        we_a = 1'b1; addr_a = 7'd5; din_a = 16'h1234; step();
        idle(); re_b = 1'b1; addr_b = 7'd5; step();
        check_val("basic_rd", 32'(o_dout_b[0]), 32'h1234);
        check_val("basic_vld", 32'(o_valid_b[0]), 32'd1);

        // read during write
        idle(); we_a = 1'b1; addr_a = 7'd9; din_a = 16'h0001; step();
        din_a = 16'h00FF; re_b = 1'b1; addr_b = 7'd9; step();
        check_val("rdw_rf", 32'(o_dout_b[0]), 32'h0001);
        check_val("rdw_wf", 32'(o_dout_b[1]), 32'h00FF);

        // write collision
        idle(); we_a = 1'b1; we_b = 1'b1; addr_a = 7'd20; addr_b = 7'd20;
        din_a = 16'hAAAA; din_b = 16'h5555; step();
        check_val("col_pulse", 32'(o_col[0]), 32'd1);
        idle(); step();
        check_val("col_clear", 32'(o_col[0]), 32'd0);
        re_a = 1'b1; addr_a = 7'd20; step();
        check_val("col_data", 32'(o_dout_a[0]), 32'hAAAA);

        // out of range on the DEPTH=100 instance
        idle(); we_a = 1'b1; addr_a = 7'd110; din_a = 16'hDEAD; step();
        idle(); re_a = 1'b1; addr_a = 7'd110; step();
        check_val("oor_rd", 32'(o_dout_a[2]), 32'h0);
        check_val("oor_vld", 32'(o_valid_a[2]), 32'd1);
        addr_a = 7'd0; step();
        check_val("oor_addr0", 32'(o_dout_a[2]), 32'h0F0F);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rand_inputs(c % 3 == 0);
            step();
        end

        // reset mid-sweep, with writes attempted while busy
        idle(); rst = 1'b1; step();
        rst = 1'b0;
        for (int c = 0; c < 50; c++) step();
        rst = 1'b1; step();
        rst = 1'b0;
        we_a = 1'b1; addr_a = 7'd3; din_a = 16'hBEEF;
        for (int c = 0; c < 127; c++) step();
        check_val("midrst_busy", 32'(o_busy[0]), 32'd1);
        idle(); step();
        check_val("midrst_ready", 32'(o_busy[0]), 32'd0);
        re_a = 1'b1; addr_a = 7'd3; step();
        check_val("busy_wr_drop", 32'(o_dout_a[0]), 32'hA5A5);

        for (int c = 0; c < 800; c++) begin
            rand_inputs(c % 2 == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
